ccip_rx_bookkeeper: RTL

- Sits directly downstream of the CPU-NIC polling stage.
- Consumes its "new RPC accepted" events: flow id plus queue entry index.
- Keeps a per-flow consumed-head pointer and coalesces updates.
- Emits batched eREQ_WRPUSH_I writes to the CPU bookkeeping region (rx_bk_base_addr), so software can recycle RX slots. The writes go out on a valid/ready request port into the C1 arbiter shared with the transmitter.

---
 rtl/ccip_rx_bookkeeper_pkg.sv | 67 ++++++
 rtl/ccip_rx_bookkeeper.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/ccip_rx_bookkeeper_pkg.sv
// Shared types for the RX bookkeeping path: the CCI-P subset used by the C1 write port,
// the bookkeeper FSM states and the per-flow table entry.
package ccip_rx_bookkeeper_pkg;

    localparam int CCIP_CLADDR_WIDTH = 42;
    localparam int CCIP_CLDATA_WIDTH = 512;
    localparam int CCIP_MDATA_WIDTH  = 16;

    typedef logic [CCIP_CLADDR_WIDTH-1:0] t_ccip_clAddr;
    typedef logic [CCIP_CLDATA_WIDTH-1:0] t_ccip_clData;
    typedef logic [CCIP_MDATA_WIDTH-1:0]  t_ccip_mdata;

    typedef enum logic [1:0] {
        eVC_VA  = 2'h0,
        eVC_VL0 = 2'h1,
        eVC_VH0 = 2'h2,
        eVC_VH1 = 2'h3
    } t_ccip_vc;

    typedef enum logic [1:0] {
        eCL_LEN_1 = 2'h0,
        eCL_LEN_2 = 2'h1,
        eCL_LEN_4 = 2'h3
    } t_ccip_clLen;

    typedef enum logic [3:0] {
        eREQ_WRLINE_I = 4'h0,
        eREQ_WRLINE_M = 4'h1,
        eREQ_WRPUSH_I = 4'h2,
        eREQ_WRFENCE  = 4'h4,
        eREQ_INTR     = 4'h6
    } t_ccip_c1_req;

    typedef struct packed {
        logic [5:0]   rsvd2;
        t_ccip_vc     vc_sel;
        logic         sop;
        logic         rsvd1;
        t_ccip_clLen  cl_len;
        t_ccip_c1_req req_type;
        logic [5:0]   rsvd0;
        t_ccip_clAddr address;
        t_ccip_mdata  mdata;
    } t_ccip_c1_ReqMemHdr;

    typedef enum logic [0:0] {
        BkScan  = 1'b0,
        BkIssue = 1'b1
    } BkState;

    localparam int BK_DATA_HEAD_LSB = 0;
    localparam int BK_DATA_CNT_LSB  = 16;
    localparam int BK_FIELD_W       = 16;

    // Fields are sized for the widest supported head/count; unused upper bits stay zero.
    typedef struct packed {
        logic [BK_FIELD_W-1:0] head;
        logic [BK_FIELD_W-1:0] count;
        logic                  dirty;
    } BkEntry;

    function automatic logic [BK_FIELD_W-1:0] bk_sat_inc(input logic [BK_FIELD_W-1:0] value,
                                                         input logic [BK_FIELD_W-1:0] max);
        return (value >= max) ? max : value + BK_FIELD_W'(1);
    endfunction

endpackage

// File: rtl/ccip_rx_bookkeeper.sv
// Tracks per-flow consumed RX heads and pushes coalesced head/count updates to the CPU
// bookkeeping region, one cache line per flow.
module ccip_rx_bookkeeper
    import ccip_rx_bookkeeper_pkg::*;
#(
    parameter int LMAX_NUM_OF_FLOWS  = 1,
    parameter int LMAX_RX_QUEUE_SIZE = 1,
    parameter int BK_TIMEOUT         = 64,
    parameter int CNT_W              = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [LMAX_NUM_OF_FLOWS-1:0]  number_of_flows,
    input  t_ccip_clAddr                  rx_bk_base_addr,
    input  logic [LMAX_RX_QUEUE_SIZE-1:0] rx_queue_size,
    input  logic [CNT_W-1:0]              bk_threshold,
    input  logic                          ev_valid,
    input  logic [LMAX_NUM_OF_FLOWS-1:0]  ev_flow_id,
    input  logic [LMAX_RX_QUEUE_SIZE-1:0] ev_entry,
    output logic                          bk_wr_valid,
    input  logic                          bk_wr_ready,
    output t_ccip_c1_ReqMemHdr            bk_wr_hdr,
    output t_ccip_clData                  bk_wr_data,
    output logic [31:0]                   bk_writes_cnt,
    output logic                          error
);

    localparam int NF = 2 ** LMAX_NUM_OF_FLOWS;
    localparam int TW = (BK_TIMEOUT > 1) ? $clog2(BK_TIMEOUT) : 1;
    localparam logic [BK_FIELD_W-1:0] CNT_MAX = BK_FIELD_W'((1 << CNT_W) - 1);

    BkEntry                       table_q [NF];
    BkState                       state;
    logic [LMAX_NUM_OF_FLOWS-1:0] ptr;
    logic [TW-1:0]                timer;
    logic                         flush_all;
    logic                         flush_pass;

    BkEntry                       cur;
    logic [BK_FIELD_W-1:0]        thr_eff;
    logic                         qualify;
    logic                         snap_take;
    logic                         ev_legal;
    logic [BK_FIELD_W-1:0]        ev_head;
    logic                         ptr_advance;
    logic                         ptr_wrap;
    logic [LMAX_NUM_OF_FLOWS-1:0] ptr_next;
    logic                         timer_hit;
    t_ccip_c1_ReqMemHdr           hdr_next;
    t_ccip_clData                 data_next;

    always_comb begin
        cur         = table_q[ptr];
        thr_eff     = (bk_threshold == '0) ? BK_FIELD_W'(1) : BK_FIELD_W'(bk_threshold);
        qualify     = cur.dirty && ((cur.count >= thr_eff) || flush_all);
        snap_take   = (state == BkScan) && start && qualify;
        ev_legal    = ev_valid && (ev_flow_id <= number_of_flows);
        ev_head     = (ev_entry == rx_queue_size) ? '0 : BK_FIELD_W'(ev_entry) + BK_FIELD_W'(1);
        ptr_advance = ((state == BkScan) && start && !qualify) ||
                      ((state == BkIssue) && bk_wr_ready);
        ptr_wrap    = (ptr >= number_of_flows);
        ptr_next    = ptr_wrap ? '0 : ptr + LMAX_NUM_OF_FLOWS'(1);
        timer_hit   = start && (timer == TW'(BK_TIMEOUT - 1));

        hdr_next          = '0;
        hdr_next.req_type = eREQ_WRPUSH_I;
        hdr_next.vc_sel   = eVC_VH0;
        hdr_next.sop      = 1'b1;
        hdr_next.cl_len   = eCL_LEN_1;
        hdr_next.address  = rx_bk_base_addr + CCIP_CLADDR_WIDTH'(ptr);

        data_next = '0;
        data_next[BK_DATA_HEAD_LSB +: BK_FIELD_W] = cur.head;
        data_next[BK_DATA_CNT_LSB +: BK_FIELD_W]  = cur.count;
    end

    // An event landing on the flow being snapshotted restarts its count at one.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NF; i++) begin
                table_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NF; i++) begin
                if (ev_legal && (ev_flow_id == LMAX_NUM_OF_FLOWS'(i))) begin
                    table_q[i].head  <= ev_head;
                    table_q[i].count <= (snap_take && (ptr == LMAX_NUM_OF_FLOWS'(i))) ?
                                        BK_FIELD_W'(1) : bk_sat_inc(table_q[i].count, CNT_MAX);
                    table_q[i].dirty <= 1'b1;
                end else if (snap_take && (ptr == LMAX_NUM_OF_FLOWS'(i))) begin
                    table_q[i].count <= '0;
                    table_q[i].dirty <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= BkScan;
            ptr           <= '0;
            timer         <= '0;
            flush_all     <= 1'b0;
            flush_pass    <= 1'b0;
            bk_wr_valid   <= 1'b0;
            bk_wr_hdr     <= '0;
            bk_wr_data    <= '0;
            bk_writes_cnt <= '0;
            error         <= 1'b0;
        end else begin
            if (start) begin
                timer <= timer_hit ? '0 : timer + TW'(1);
            end

            // Hold flush_all across one complete pass starting from flow 0 so every
            // flow is visited regardless of where the pointer was when the timer fired.
            if (timer_hit) begin
                flush_all  <= 1'b1;
                flush_pass <= 1'b0;
            end else if (ptr_advance && ptr_wrap && flush_all) begin
                if (flush_pass) begin
                    flush_all <= 1'b0;
                end else begin
                    flush_pass <= 1'b1;
                end
            end

            if (ptr_advance) begin
                ptr <= ptr_next;
            end

            if (ev_valid && !ev_legal) begin
                error <= 1'b1;
            end

            unique case (state)
                BkScan: begin
                    if (snap_take) begin
                        state       <= BkIssue;
                        bk_wr_valid <= 1'b1;
                        bk_wr_hdr   <= hdr_next;
                        bk_wr_data  <= data_next;
                    end
                end
                BkIssue: begin
                    if (bk_wr_ready) begin
                        state         <= BkScan;
                        bk_wr_valid   <= 1'b0;
                        bk_writes_cnt <= bk_writes_cnt + 32'd1;
                    end
                end
                default: state <= BkScan;
            endcase
        end
    end

endmodule
